ps2_mouse_packet_rx: RTL and testbench

//  Receive-side front end of the PS/2 mouse path. Samples device-driven ps2_c/ps2_d,

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_byte_rx.sv | 130 +++++++++++++
 rtl/ps2_mouse_packet_rx.sv | 120 ++++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 mouse receive path.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 3;
    localparam int unsigned PKT_BYTES  = 3;

    // Mouse packet byte 0 bit positions
    localparam int unsigned B0_LEFT   = 0;
    localparam int unsigned B0_RIGHT  = 1;
    localparam int unsigned B0_MIDDLE = 2;
    localparam int unsigned B0_SYNC   = 3;
    localparam int unsigned B0_XSIGN  = 4;
    localparam int unsigned B0_YSIGN  = 5;
    localparam int unsigned B0_XOVF   = 6;
    localparam int unsigned B0_YOVF   = 7;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } bit_state_e;

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: input synchronisers, clock glitch filter, frame deserialiser and
// inactivity timeout.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_c,
    input  logic       ps2_d,
    output logic       byte_done,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       abort
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
    localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0]   ToLast  = ToW'(TIMEOUT_CYCLES - 1);

    logic             c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic             c_filt_q, c_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    bit_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             fall_evt;

    // The filtered clock only follows the synchronised clock after a full stable run
    assign fall_evt = c_filt_q && !c_sync_q && (filt_cnt_q == FiltMax);
    assign abort    = !fall_evt && (to_cnt_q == ToLast);
    assign data     = shift_q;

    always_comb begin
        c_filt_d   = c_filt_q;
        filt_cnt_d = filt_cnt_q;
        if (c_sync_q == c_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FiltMax) begin
            c_filt_d   = c_sync_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end

        if (fall_evt) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == ToMax) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        if (fall_evt) begin
            case (state_q)
                StIdle: begin
                    if (!d_sync_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {d_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = d_sync_q;
                    state_d = StStop;
                end
                StStop: begin
                    if (d_sync_q && (^{shift_q, par_q})) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (abort) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_meta_q   <= 1'b1;
            c_sync_q   <= 1'b1;
            d_meta_q   <= 1'b1;
            d_sync_q   <= 1'b1;
            c_filt_q   <= 1'b1;
            filt_cnt_q <= '0;
            to_cnt_q   <= '0;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
        end else begin
            c_meta_q   <= ps2_c;
            c_sync_q   <= c_meta_q;
            d_meta_q   <= ps2_d;
            d_sync_q   <= d_meta_q;
            c_filt_q   <= c_filt_d;
            filt_cnt_q <= filt_cnt_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receive front end: assembles 3-byte streaming packets into signed deltas
// and button state.
module ps2_mouse_packet_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_c,
    input  logic       ps2_d,
    output logic       pkt_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [2:0] btn,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       frame_err
);

    localparam int unsigned IdxW = $clog2(PKT_BYTES);

    logic            rx_byte_done, rx_frame_err, rx_abort;
    logic [7:0]      rx_data;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      b0_q, b0_d, b1_q, b1_d;
    logic [8:0]      dx_q, dx_d, dy_q, dy_d;
    logic [2:0]      btn_q, btn_d;
    logic            x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
    logic            pkt_valid_q, pkt_valid_d, frame_err_q, frame_err_d;

    ps2_byte_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_c     (ps2_c),
        .ps2_d     (ps2_d),
        .byte_done (rx_byte_done),
        .data      (rx_data),
        .frame_err (rx_frame_err),
        .abort     (rx_abort)
    );

    always_comb begin
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        btn_d       = btn_q;
        x_ovf_d     = x_ovf_q;
        y_ovf_d     = y_ovf_q;
        pkt_valid_d = 1'b0;
        frame_err_d = rx_frame_err;
        if (rx_frame_err || rx_abort) begin
            idx_d = '0;
        end else if (rx_byte_done) begin
            case (idx_q)
                IdxW'(0): begin
                    // Byte 0 always has bit 3 set; anything else is a misaligned byte
                    if (rx_data[B0_SYNC]) begin
                        b0_d  = rx_data;
                        idx_d = IdxW'(1);
                    end
                end
                IdxW'(1): begin
                    b1_d  = rx_data;
                    idx_d = IdxW'(2);
                end
                default: begin
                    idx_d       = '0;
                    pkt_valid_d = 1'b1;
                    x_ovf_d     = b0_q[B0_XOVF];
                    y_ovf_d     = b0_q[B0_YOVF];
                    dx_d        = b0_q[B0_XOVF] ? 9'd0 : {b0_q[B0_XSIGN], b1_q};
                    dy_d        = b0_q[B0_YOVF] ? 9'd0 : {b0_q[B0_YSIGN], rx_data};
                    btn_d       = {b0_q[B0_MIDDLE], b0_q[B0_RIGHT], b0_q[B0_LEFT]};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            btn_q       <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            btn_q       <= btn_d;
            x_ovf_q     <= x_ovf_d;
            y_ovf_q     <= y_ovf_d;
            pkt_valid_q <= pkt_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign frame_err = frame_err_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign btn       = btn_q;
    assign x_ovf     = x_ovf_q;
    assign y_ovf     = y_ovf_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Self-checking bench for ps2_mouse_packet_rx: directed scenarios plus random packets
// against a byte-level packet model.
module tb_ps2_mouse_packet_rx;

    logic       clk = 1'b0;
    logic       rst, ps2_c, ps2_d;
    logic       pkt_valid, x_ovf, y_ovf, frame_err;
    logic [8:0] dx, dy;
    logic [2:0] btn;

    ps2_mouse_packet_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_c     (ps2_c),
        .ps2_d     (ps2_d),
        .pkt_valid (pkt_valid),
        .dx        (dx),
        .dy        (dy),
        .btn       (btn),
        .x_ovf     (x_ovf),
        .y_ovf     (y_ovf),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [8:0] dx;
        logic [8:0] dy;
        logic [2:0] btn;
        logic       xo;
        logic       yo;
    } pkt_t;

    pkt_t       exp_q[$];
    pkt_t       cur = '0;
    logic [7:0] m_b[3];
    int         m_idx = 0;
    int         exp_ferr = 0;
    int         pkt_seen = 0;
    int         ferr_seen = 0;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic pkt_t decode(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2);
        pkt_t p;
        p.xo  = b0[6];
        p.yo  = b0[7];
        p.dx  = p.xo ? 9'd0 : 9'((int'(b0[4]) * 256) + int'(b1));
        p.dy  = p.yo ? 9'd0 : 9'((int'(b0[5]) * 256) + int'(b2));
        p.btn = {b0[2], b0[1], b0[0]};
        return p;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            exp_ferr++;
            m_idx = 0;
        end else if (m_idx == 0 && !b[3]) begin
            m_idx = 0;
        end else begin
            m_b[m_idx] = b;
            m_idx++;
            if (m_idx == 3) begin
                exp_q.push_back(decode(m_b[0], m_b[1], m_b[2]));
                m_idx = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rst_at >= 0 pulses reset at the start of that frame bit and abandons the frame
    task automatic send_frame(input logic [7:0] b, input bit bad, input int rst_at);
        logic [10:0] fr;
        logic        p;
        p  = (~^b) ^ bad;
        fr = {1'b1, p, b, 1'b0};
        if (rst_at < 0) model_byte(b, bad);
        for (int i = 0; i < 11; i++) begin
            if (i == rst_at) begin
                m_idx = 0;
                rst   = 1'b1;
                wait_clk(1);
                rst   = 1'b0;
                ps2_c = 1'b1;
                ps2_d = 1'b1;
                wait_clk(100);
                return;
            end
            ps2_d = fr[i];
            wait_clk(50);
            ps2_c = 1'b0;
            wait_clk(50);
            ps2_c = 1'b1;
        end
        ps2_d = 1'b1;
        wait_clk(100);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, -1);
        send_frame(b1, 1'b0, -1);
        send_frame(b2, 1'b0, -1);
    endtask

    // Every cycle: strobes must match the model's queue, held outputs the last packet
    always @(negedge clk) begin
        if (rst) begin
            cur = '0;
        end else begin
            if (pkt_valid) begin
                pkt_seen++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pkt_valid: got 1, expected 0 (no packet pending)");
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (frame_err) begin
                ferr_seen++;
                vectors++;
                if (exp_ferr == 0) begin
                    miscompares++;
                    $display("FAIL frame_err: got 1, expected 0");
                end else begin
                    exp_ferr--;
                end
            end
            vectors++;
            if ({dx, dy, btn, x_ovf, y_ovf} !== cur) begin
                miscompares++;
                $display("FAIL outputs: got dx=%h dy=%h btn=%b xo=%b yo=%b, expected dx=%h dy=%h btn=%b xo=%b yo=%b",
                         dx, dy, btn, x_ovf, y_ovf, cur.dx, cur.dy, cur.btn, cur.xo, cur.yo);
            end
        end
    end

    initial begin
        int pk, fe;
        logic [7:0] b;
        bit bad;
        rst   = 1'b1;
        ps2_c = 1'b1;
        ps2_d = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check("reset_dx", 16'(dx), 16'h000);
        check("reset_dy", 16'(dy), 16'h000);
        check("reset_flags", 16'({btn, x_ovf, y_ovf, pkt_valid, frame_err}), 16'h0);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(20);

        pk = pkt_seen;
        send_pkt(8'h29, 8'h05, 8'hFB);
        @(negedge clk);
        check("t1_count", 16'(pkt_seen - pk), 16'd1);
        check("t1_dx", 16'(dx), 16'h005);
        check("t1_dy", 16'(dy), 16'h1FB);
        check("t1_btn", 16'(btn), 16'b001);
        check("t1_ovf", 16'({x_ovf, y_ovf}), 16'b00);

        pk = pkt_seen;
        fe = ferr_seen;
        send_frame(8'h29, 1'b0, -1);
        send_frame(8'h05, 1'b1, -1);
        @(negedge clk);
        check("t2_ferr", 16'(ferr_seen - fe), 16'd1);
        check("t2_nopkt", 16'(pkt_seen - pk), 16'd0);
        send_pkt(8'h0A, 8'h10, 8'h20);
        @(negedge clk);
        check("t2_count", 16'(pkt_seen - pk), 16'd1);
        check("t2_dx", 16'(dx), 16'h010);
        check("t2_dy", 16'(dy), 16'h020);
        check("t2_btn", 16'(btn), 16'b010);

        pk = pkt_seen;
        send_frame(8'h00, 1'b0, -1);
        send_pkt(8'h0C, 8'h01, 8'h01);
        @(negedge clk);
        check("t3_count", 16'(pkt_seen - pk), 16'd1);
        check("t3_dx", 16'(dx), 16'h001);
        check("t3_dy", 16'(dy), 16'h001);
        check("t3_btn", 16'(btn), 16'b100);

        pk = pkt_seen;
        send_frame(8'h08, 1'b0, -1);
        send_frame(8'h7F, 1'b0, -1);
        wait_clk(2500);
        m_idx = 0;
        send_pkt(8'h18, 8'hFF, 8'h02);
        @(negedge clk);
        check("t4_count", 16'(pkt_seen - pk), 16'd1);
        check("t4_dx", 16'(dx), 16'h1FF);
        check("t4_dy", 16'(dy), 16'h002);

        send_pkt(8'h58, 8'h80, 8'h03);
        @(negedge clk);
        check("t5_dx", 16'(dx), 16'h000);
        check("t5_xovf", 16'(x_ovf), 16'd1);
        check("t5_dy", 16'(dy), 16'h003);
        check("t5_yovf", 16'(y_ovf), 16'd0);
        fe = ferr_seen;
        pk = pkt_seen;
        wait_clk(20);
        ps2_c = 1'b0;
        wait_clk(4);
        ps2_c = 1'b1;
        wait_clk(60);
        check("t5_glitch_ferr", 16'(ferr_seen - fe), 16'd0);
        check("t5_glitch_pkt", 16'(pkt_seen - pk), 16'd0);

        send_frame(8'h09, 1'b0, -1);
        send_frame(8'h02, 1'b0, -1);
        send_frame(8'h03, 1'b0, 4);
        @(negedge clk);
        check("t6_rst_dx", 16'(dx), 16'h000);
        check("t6_rst_dy", 16'(dy), 16'h000);
        check("t6_rst_flags", 16'({btn, x_ovf, y_ovf}), 16'h0);
        pk = pkt_seen;
        send_pkt(8'h09, 8'h02, 8'h03);
        @(negedge clk);
        check("t6_count", 16'(pkt_seen - pk), 16'd1);
        check("t6_dx", 16'(dx), 16'h002);
        check("t6_dy", 16'(dy), 16'h003);
        check("t6_btn", 16'(btn), 16'b001);

        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 3; j++) begin
                b   = 8'($urandom);
                if (j == 0 && $urandom_range(3) != 0) b[3] = 1'b1;
                bad = ($urandom_range(7) == 0);
                send_frame(b, bad, -1);
            end
        end

        wait_clk(50);
        check("end_pkts_pending", 16'(exp_q.size()), 16'd0);
        check("end_ferr_pending", 16'(exp_ferr), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
